// File: rtl/board_pkg.sv
// Shared VGA 640x480@60 raster constants, colour palette and small helpers
// for the board rendering path.
package board_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COL_BLACK  = 12'h000;
  localparam rgb_t COL_BG     = 12'h002;
  localparam rgb_t COL_GROUND = 12'h0F0;
  localparam rgb_t COL_PLAYER = 12'hFFF;
  localparam rgb_t COL_DEAD   = 12'hF00;

  // Half-open interval test [lo, hi) on an unsigned row/column value.
  function automatic logic in_span(input logic [10:0] val,
                                   input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/board_renderer_timing.sv
// Raster generator: pixel-tick divider, horizontal/vertical beam counters,
// raw (unregistered) sync levels, visible-area flag and end-of-frame strobe.
module vga_timing
  import board_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible,
  output logic       frame_end
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] H_VIS_W   = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W   = 10'(V_VIS);

  logic [DIV_W-1:0] div;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign hsync_raw = !((h >= H_SYNC_LO) && (h < H_SYNC_HI));
  assign vsync_raw = !((v >= V_SYNC_LO) && (v < V_SYNC_HI));
  assign visible   = (h < H_VIS_W) && (v < V_VIS_W);
  assign frame_end = tick && (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/board_renderer.sv
// Display end of the ground pipeline: per-frame snapshot of ground bitmaps
// and player state, colour priority, and registered VGA sync/RGB outputs.
module board_renderer
  import board_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int TOP_Y    = 120,
  parameter int MID_Y    = 240,
  parameter int BOT_Y    = 360,
  parameter int GROUND_H = 8,
  parameter int PLAYER_X = 20,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_game,
  input  logic         is_dead,
  input  logic [639:0] ground_top,
  input  logic [639:0] ground_middle,
  input  logic [639:0] ground_bottom,
  input  logic [8:0]   height,
  output logic         hsync,
  output logic         vsync,
  output logic [3:0]   red,
  output logic [3:0]   green,
  output logic [3:0]   blue,
  output logic [9:0]   hcount,
  output logic [9:0]   vcount,
  output logic         frame_start
);

  localparam logic [10:0] TOP_LO = 11'(TOP_Y);
  localparam logic [10:0] TOP_HI = 11'(TOP_Y + GROUND_H);
  localparam logic [10:0] MID_LO = 11'(MID_Y);
  localparam logic [10:0] MID_HI = 11'(MID_Y + GROUND_H);
  localparam logic [10:0] BOT_LO = 11'(BOT_Y);
  localparam logic [10:0] BOT_HI = 11'(BOT_Y + GROUND_H);
  localparam logic [9:0]  PX_LO  = 10'(PLAYER_X);
  localparam logic [9:0]  PX_HI  = 10'(PLAYER_X + PLAYER_W);
  localparam logic [9:0]  PH     = 10'(PLAYER_H);

  logic       tick;
  logic [9:0] h;
  logic [9:0] v;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       vis_p0;
  logic       frame_end;

  vga_timing #(
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .h        (h),
    .v        (v),
    .hsync_raw(hsync_raw),
    .vsync_raw(vsync_raw),
    .visible  (vis_p0),
    .frame_end(frame_end)
  );

  logic [639:0] sh_top;
  logic [639:0] sh_mid;
  logic [639:0] sh_bot;
  logic [8:0]   sh_height;
  logic         sh_game;
  logic         sh_dead;

  // Snapshot once per frame, during blanking, so scrolling never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_top    <= '0;
      sh_mid    <= '0;
      sh_bot    <= '0;
      sh_height <= '0;
      sh_game   <= 1'b0;
      sh_dead   <= 1'b0;
    end else if (frame_end) begin
      sh_top    <= ground_top;
      sh_mid    <= ground_middle;
      sh_bot    <= ground_bottom;
      sh_height <= height;
      sh_game   <= in_game;
      sh_dead   <= is_dead;
    end
  end

  // Stage p0: colour of the pixel at the current counter position.
  logic [9:0]  hx_p0;
  logic [10:0] vw_p0;
  logic [9:0]  py_lo_p0;
  logic [9:0]  py_hi_p0;
  logic        in_player_p0;
  logic        in_ground_p0;
  rgb_t        col_p0;

  always_comb begin
    hx_p0        = vis_p0 ? h : '0;
    vw_p0        = {1'b0, v};
    py_lo_p0     = {1'b0, sh_height};
    py_hi_p0     = py_lo_p0 + PH;
    in_player_p0 = sh_game && (h >= PX_LO) && (h < PX_HI)
                   && (v >= py_lo_p0) && (v < py_hi_p0);
    in_ground_p0 = (in_span(vw_p0, TOP_LO, TOP_HI) && sh_top[hx_p0])
                   || (in_span(vw_p0, MID_LO, MID_HI) && sh_mid[hx_p0])
                   || (in_span(vw_p0, BOT_LO, BOT_HI) && sh_bot[hx_p0]);
    col_p0       = COL_BG;
    if (!vis_p0) begin
      col_p0 = COL_BLACK;
    end else if (in_player_p0) begin
      col_p0 = sh_dead ? COL_DEAD : COL_PLAYER;
    end else if (in_ground_p0) begin
      col_p0 = COL_GROUND;
    end
  end

  // Stage p1: syncs, colour and coordinates registered together on the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (tick) begin
        hsync              <= hsync_raw;
        vsync              <= vsync_raw;
        {red, green, blue} <= col_p0;
        hcount             <= h;
        vcount             <= v;
      end
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Randomized bench for board_renderer: every clock is compared with a
// pixel-level reference model; spot pixels and sync widths are checked directly.
module tb_board_renderer;

  localparam int CLK_DIV  = 2;
  localparam int TOP_Y    = 120;
  localparam int MID_Y    = 240;
  localparam int BOT_Y    = 360;
  localparam int GROUND_H = 8;
  localparam int PLAYER_X = 20;
  localparam int PLAYER_W = 16;
  localparam int PLAYER_H = 16;
  localparam int MAX_CLKS = 4 * 800 * 525 * CLK_DIV;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_game = 1'b0;
  logic         is_dead = 1'b0;
  logic [639:0] ground_top = '0;
  logic [639:0] ground_middle = '0;
  logic [639:0] ground_bottom = '0;
  logic [8:0]   height = '0;
  logic         hsync;
  logic         vsync;
  logic [3:0]   red;
  logic [3:0]   green;
  logic [3:0]   blue;
  logic [9:0]   hcount;
  logic [9:0]   vcount;
  logic         frame_start;

  board_renderer #(
    .CLK_DIV (CLK_DIV),
    .TOP_Y   (TOP_Y),
    .MID_Y   (MID_Y),
    .BOT_Y   (BOT_Y),
    .GROUND_H(GROUND_H),
    .PLAYER_X(PLAYER_X),
    .PLAYER_W(PLAYER_W),
    .PLAYER_H(PLAYER_H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_game      (in_game),
    .is_dead      (is_dead),
    .ground_top   (ground_top),
    .ground_middle(ground_middle),
    .ground_bottom(ground_bottom),
    .height       (height),
    .hsync        (hsync),
    .vsync        (vsync),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .hcount       (hcount),
    .vcount       (vcount),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: what the screen should be built from this frame.
  logic [639:0] m_top, m_mid, m_bot;
  int           m_height;
  bit           m_game, m_dead;

  logic         e_hs, e_vs, e_fs;
  logic [11:0]  e_rgb;
  logic [9:0]   e_hc, e_vc;

  int  n = 0;
  int  frame = 0;
  int  line_err = 0, hs_low = 0, vs_low = 0, fs_cnt = 0;
  bit  seen_fall = 0, mid_done = 0, mid_pending = 0, done = 0;
  logic [639:0] bot0, mid1;
  int  rx [4];

  function automatic logic [639:0] rand640();
    logic [639:0] r;
    for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [11:0] ref_pixel(input int x, input int y);
    bit ground;
    if (x >= 640 || y >= 480) return 12'h000;
    if (m_game && x >= PLAYER_X && x < PLAYER_X + PLAYER_W &&
        y >= m_height && y < m_height + PLAYER_H)
      return m_dead ? 12'hF00 : 12'hFFF;
    ground = (y >= TOP_Y && y < TOP_Y + GROUND_H && m_top[x]) ||
             (y >= MID_Y && y < MID_Y + GROUND_H && m_mid[x]) ||
             (y >= BOT_Y && y < BOT_Y + GROUND_H && m_bot[x]);
    return ground ? 12'h0F0 : 12'h002;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_rgb"}, {red, green, blue}, 0);
    check({tag, "_hcount"}, hcount, 0);
    check({tag, "_vcount"}, vcount, 0);
    check({tag, "_frame_start"}, frame_start, 0);
  endtask

  task automatic point_checks(input int f, input int x, input int y);
    logic [11:0] obs;
    obs = {red, green, blue};
    if (f == 0) begin
      if (x == 100 && y == TOP_Y) check("f0_bg_top", obs, 12'h002);
      if (x == 20  && y == TOP_Y) check("f0_no_player", obs, 12'h002);
      if (x == 300 && y == MID_Y) check("f0_bg_mid", obs, 12'h002);
    end else if (f == 1) begin
      if (x == 20  && y == TOP_Y)     check("f1_player", obs, 12'hFFF);
      if (x == 36  && y == TOP_Y)     check("f1_right_of_player", obs, 12'h0F0);
      if (x == 35  && y == TOP_Y + 11) check("f1_player_corner", obs, 12'hFFF);
      if (x == 20  && y == TOP_Y + 12) check("f1_below_player", obs, 12'h002);
      if (x == 100 && y == TOP_Y + 7) check("f1_top_last_row", obs, 12'h0F0);
      if (x == 100 && y == TOP_Y + 8) check("f1_top_after_band", obs, 12'h002);
      if (x == 300 && y == MID_Y + 3) check("f1_mid_old_pattern", obs, 12'h0F0);
      if (x == 700 && y == 100)       check("f1_hblank", obs, 12'h000);
      if (x == 100 && y == 500)       check("f1_vblank", obs, 12'h000);
      for (int k = 0; k < 4; k++)
        if (x == rx[k] && y == BOT_Y + 5)
          check($sformatf("f1_bot_x%0d", x), obs, bot0[x] ? 12'h0F0 : 12'h002);
    end else if (f == 2) begin
      if (x == 100 && y == TOP_Y)     check("f2_top_bit100", obs, 12'h0F0);
      if (x == 100 && y == TOP_Y + 7) check("f2_top_bit100_last", obs, 12'h0F0);
      if (x == 101 && y == TOP_Y)     check("f2_top_bit101", obs, 12'h002);
      if (x == 100 && y == TOP_Y + 8) check("f2_top_after_band", obs, 12'h002);
      if (x == 20  && y == 0)         check("f2_no_wrap_row0", obs, 12'h002);
      if (x == 20  && y == 469)       check("f2_above_player", obs, 12'h002);
      if (x == 20  && y == 470)       check("f2_dead_player", obs, 12'hF00);
      if (x == 35  && y == 479)       check("f2_dead_clip_row", obs, 12'hF00);
      if (x == 36  && y == 479)       check("f2_right_of_dead", obs, 12'h002);
      if (x == 20  && y == 480)       check("f2_clipped_blank", obs, 12'h000);
      for (int k = 0; k < 4; k++)
        if (x == rx[k] && y == MID_Y + 2)
          check($sformatf("f2_mid_x%0d", x), obs, mid1[x] ? 12'h0F0 : 12'h002);
    end
  endtask

  task automatic step();
    bit tk;
    int pix, x, y, cidx;
    tk = 0; x = 0; y = 0; cidx = 0;
    @(posedge clk);
    #1;
    e_fs = 1'b0;
    if (reset) begin
      m_top = '0; m_mid = '0; m_bot = '0;
      m_height = 0; m_game = 0; m_dead = 0;
      n = 0; frame = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0; e_hc = '0; e_vc = '0;
      line_err = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; seen_fall = 0;
      if (mid_pending) begin
        check_reset_outputs("mid_reset");
        mid_pending = 0;
        reset = 1'b0;
      end
    end else begin
      cidx = n;
      if (n % CLK_DIV == CLK_DIV - 1) begin
        tk  = 1;
        pix = n / CLK_DIV;
        x   = pix % 800;
        y   = (pix / 800) % 525;
        e_hs  = !(x >= 656 && x < 752);
        e_vs  = !(y >= 490 && y < 492);
        e_rgb = ref_pixel(x, y);
        e_hc  = 10'(x);
        e_vc  = 10'(y);
        if (x == 799 && y == 524) begin
          e_fs = 1'b1;
          m_top = ground_top; m_mid = ground_middle; m_bot = ground_bottom;
          m_height = int'(height); m_game = in_game; m_dead = is_dead;
        end
      end
      n++;
    end

    if ({hsync, vsync, red, green, blue, hcount, vcount, frame_start} !==
        {e_hs, e_vs, e_rgb, e_hc, e_vc, e_fs})
      line_err++;
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
    if (frame_start) fs_cnt++;
    if (!reset && !hsync && !seen_fall) begin
      seen_fall = 1;
      check("hsync_first_fall_clk", cidx, 656 * CLK_DIV + CLK_DIV - 1);
    end

    if (tk) begin
      point_checks(frame, x, y);
      if (x == 799) begin
        check($sformatf("line_f%0d_v%0d_mismatches", frame, y), line_err, 0);
        check("hsync_low_clks", hs_low, 96 * CLK_DIV);
        line_err = 0;
        hs_low   = 0;
      end
      if (x == 799 && y == 524) begin
        check("vsync_low_clks", vs_low, 1600 * CLK_DIV);
        check("frame_start_count", fs_cnt, 1);
        vs_low = 0;
        fs_cnt = 0;
        frame++;
      end
      if (frame == 0 && x == 300 && y == 250 && !mid_done) begin
        mid_done    = 1;
        mid_pending = 1;
        reset       = 1'b1;
      end
      if (frame == 1 && x == 0 && y == 200) begin
        ground_middle = rand640();
        mid1          = ground_middle;
        ground_top    = '0;
        ground_top[100] = 1'b1;
        ground_bottom = rand640();
        is_dead       = 1'b1;
        height        = 9'd470;
      end
      if (frame == 2 && x == 0 && y == 481) done = 1;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) rx[k] = $urandom_range(639, 0);
    reset         = 1'b1;
    ground_top    = '1;
    ground_middle = '1;
    ground_bottom = rand640();
    bot0          = ground_bottom;
    in_game       = 1'b1;
    is_dead       = 1'b0;
    height        = 9'(TOP_Y - 4);
    repeat (3) step();
    check_reset_outputs("por");
    reset = 1'b0;
    for (int c = 0; c < MAX_CLKS && !done; c++) step();
    if (!done) check("run_timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
